// File: rtl/carrier_nco.sv
// carrier_nco: quadrature carrier NCO. A phase accumulator with a runtime FCW handshake
// drives a shared quarter-wave sine table through a 3-stage phase/ROM/sign pipeline.
module carrier_nco #(
  parameter int                 PHASE_W   = 24,
  parameter int                 LUT_AW    = 10,
  parameter int                 DATA_W    = 32,
  parameter logic [PHASE_W-1:0] FCW_RST   = {PHASE_W{1'b0}},
  parameter string              FILE_PATH = "../data/sine_quarter.mif"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic               sync_update,
  input  logic [PHASE_W-1:0] fcw_in,
  input  logic               fcw_valid,
  output logic               fcw_ready,
  input  logic [PHASE_W-1:0] phase_ofs,
  output logic [DATA_W-1:0]  carrier_i,
  output logic [DATA_W-1:0]  carrier_q,
  output logic               out_valid
);

  localparam int ROM_D = 2 ** LUT_AW;
  localparam logic [PHASE_W-1:0] QTR_TURN = {2'b01, {(PHASE_W-2){1'b0}}};

  // Table samples sit half a step off the grid, so folding by ~r is exact.
  function automatic logic [DATA_W-1:0] quarter_sine(input int k);
    real x;
    real term;
    real sum;
    real amp;
    amp  = (2.0 ** (DATA_W - 1)) - 1.0;
    x    = 6.283185307179586 * (real'(k) + 0.5) / (2.0 ** (LUT_AW + 2));
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return DATA_W'($rtoi(amp * sum + 0.5));
  endfunction

  // The table is built from its closed form; FILE_PATH names the matching memory image.
  if (FILE_PATH == "") begin : g_builtin_table_only
  end

  logic [DATA_W-1:0] rom [ROM_D];
  for (genvar k = 0; k < ROM_D; k++) begin : g_rom
    assign rom[k] = quarter_sine(k);
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d;
  logic [PHASE_W-1:0] pend_fcw_q, pend_fcw_d;
  logic               pending_q, pending_d;
  logic               fcw_ready_q, fcw_ready_d;
  logic [LUT_AW-1:0]  addr_i_q, addr_i_d, addr_q_q, addr_q_d;
  logic               neg_i_q, neg_i_d, neg_q_q, neg_q_d;
  logic [DATA_W-1:0]  rom_i_q, rom_i_d, rom_q_q, rom_q_d;
  logic               neg_i2_q, neg_i2_d, neg_q2_q, neg_q2_d;
  logic               vld1_q, vld1_d, vld2_q, vld2_d;
  logic [DATA_W-1:0]  carrier_i_q, carrier_i_d, carrier_q_q, carrier_q_d;
  logic               out_valid_q, out_valid_d;

  logic [PHASE_W:0]   acc_sum;
  logic               wrap;
  logic [PHASE_W-1:0] pi;
  logic [PHASE_W-1:0] pq;
  logic               unused_phase_bits;

  // Accumulator and FCW handshake; a pending word lands on the next wrap or clear.
  always_comb begin
    acc_sum     = {1'b0, acc_q} + {1'b0, fcw_q};
    wrap        = en & ~phase_clr & acc_sum[PHASE_W];
    acc_d       = acc_q;
    fcw_d       = fcw_q;
    pend_fcw_d  = pend_fcw_q;
    pending_d   = pending_q;
    if (phase_clr) begin
      acc_d = {PHASE_W{1'b0}};
    end else if (en) begin
      acc_d = acc_sum[PHASE_W-1:0];
    end else begin
      acc_d = acc_q;
    end
    if (pending_q) begin
      if (phase_clr || wrap) begin
        fcw_d     = pend_fcw_q;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (fcw_valid) begin
      if (sync_update) begin
        pend_fcw_d = fcw_in;
        pending_d  = 1'b1;
      end else begin
        fcw_d = fcw_in;
      end
    end else begin
      pending_d = 1'b0;
    end
    fcw_ready_d = ~pending_d;
  end

  // Phase fold, table read and sign apply; stages run every cycle so offset changes propagate.
  always_comb begin
    pi          = acc_q + phase_ofs;
    pq          = pi + QTR_TURN;
    addr_i_d    = pi[PHASE_W-2] ? ~pi[PHASE_W-3 -: LUT_AW] : pi[PHASE_W-3 -: LUT_AW];
    addr_q_d    = pq[PHASE_W-2] ? ~pq[PHASE_W-3 -: LUT_AW] : pq[PHASE_W-3 -: LUT_AW];
    neg_i_d     = pi[PHASE_W-1];
    neg_q_d     = pq[PHASE_W-1];
    rom_i_d     = rom[addr_i_q];
    rom_q_d     = rom[addr_q_q];
    neg_i2_d    = neg_i_q;
    neg_q2_d    = neg_q_q;
    carrier_i_d = neg_i2_q ? ({DATA_W{1'b0}} - rom_i_q) : rom_i_q;
    carrier_q_d = neg_q2_q ? ({DATA_W{1'b0}} - rom_q_q) : rom_q_q;
    vld1_d      = en;
    vld2_d      = vld1_q;
    out_valid_d = vld2_q;
  end

  assign unused_phase_bits = ^{pi, pq};

  // State and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= {PHASE_W{1'b0}};
      fcw_q       <= FCW_RST;
      pend_fcw_q  <= {PHASE_W{1'b0}};
      pending_q   <= 1'b0;
      fcw_ready_q <= 1'b1;
      addr_i_q    <= {LUT_AW{1'b0}};
      addr_q_q    <= {LUT_AW{1'b0}};
      neg_i_q     <= 1'b0;
      neg_q_q     <= 1'b0;
      rom_i_q     <= {DATA_W{1'b0}};
      rom_q_q     <= {DATA_W{1'b0}};
      neg_i2_q    <= 1'b0;
      neg_q2_q    <= 1'b0;
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      carrier_i_q <= {DATA_W{1'b0}};
      carrier_q_q <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fcw_q       <= fcw_d;
      pend_fcw_q  <= pend_fcw_d;
      pending_q   <= pending_d;
      fcw_ready_q <= fcw_ready_d;
      addr_i_q    <= addr_i_d;
      addr_q_q    <= addr_q_d;
      neg_i_q     <= neg_i_d;
      neg_q_q     <= neg_q_d;
      rom_i_q     <= rom_i_d;
      rom_q_q     <= rom_q_d;
      neg_i2_q    <= neg_i2_d;
      neg_q2_q    <= neg_q2_d;
      vld1_q      <= vld1_d;
      vld2_q      <= vld2_d;
      carrier_i_q <= carrier_i_d;
      carrier_q_q <= carrier_q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fcw_ready = fcw_ready_q;
  assign carrier_i = carrier_i_q;
  assign carrier_q = carrier_q_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_carrier_nco.sv
// Directed self-checking bench for carrier_nco at PHASE_W=24, LUT_AW=10, DATA_W=32.
module tb_carrier_nco;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        phase_clr = 1'b0;
  logic        sync_update = 1'b0;
  logic [23:0] fcw_in = 24'h0;
  logic        fcw_valid = 1'b0;
  logic        fcw_ready;
  logic [23:0] phase_ofs = 24'h0;
  logic [31:0] carrier_i;
  logic [31:0] carrier_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  // Hand-computed: round((2^31-1)*sin(pi/4096)) and round((2^31-1)*cos(pi/4096)).
  localparam logic [31:0] L0   = 32'd1647099;
  localparam logic [31:0] LMAX = 32'd2147483015;

  logic [31:0] seqi [4];

  carrier_nco dut (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .sync_update(sync_update),
    .fcw_in(fcw_in), .fcw_valid(fcw_valid), .fcw_ready(fcw_ready), .phase_ofs(phase_ofs),
    .carrier_i(carrier_i), .carrier_q(carrier_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lref(input int k);
    real a;
    a = 2147483647.0 * $sin(6.283185307179586 * (real'(k) + 0.5) / 4096.0);
    return 32'($rtoi(a + 0.5));
  endfunction

  function automatic logic [31:0] neg(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    seqi[0] = L0;
    seqi[1] = LMAX;
    seqi[2] = neg(L0);
    seqi[3] = neg(LMAX);

    // Reset state
    step(2);
    check("rst_i", carrier_i, 32'd0);
    check("rst_q", carrier_q, 32'd0);
    check_bit("rst_valid", out_valid, 1'b0);
    check_bit("rst_ready", fcw_ready, 1'b1);

    // Release with en=1, fcw=0: valid rises on the third edge
    rst = 1'b0;
    en  = 1'b1;
    step(2);
    check_bit("lat_valid_early", out_valid, 1'b0);
    step(1);
    check_bit("lat_valid", out_valid, 1'b1);
    check("lat_i", carrier_i, L0);
    check("lat_q", carrier_q, LMAX);
    step(1);
    check("hold_i", carrier_i, L0);

    // Quarter-turn step, immediate update
    fcw_in    = 24'h400000;
    fcw_valid = 1'b1;
    step(1);
    fcw_valid = 1'b0;
    step(3);
    for (int n = 1; n <= 8; n++) begin
      step(1);
      check("quarter_i", carrier_i, seqi[2'(n)]);
      check("quarter_q", carrier_q, seqi[2'(n + 1)]);
    end

    // Coherent update: step 2^20 from a cleared accumulator, 2^21 held until wrap
    fcw_in    = 24'h100000;
    fcw_valid = 1'b1;
    phase_clr = 1'b1;
    step(1);
    fcw_valid = 1'b0;
    phase_clr = 1'b0;
    step(2);
    fcw_in      = 24'h200000;
    fcw_valid   = 1'b1;
    sync_update = 1'b1;
    step(1);
    check_bit("sync_ready_drop", fcw_ready, 1'b0);
    fcw_in = 24'h800000;
    step(4);
    fcw_valid = 1'b0;
    check_bit("sync_ready_ignored", fcw_ready, 1'b0);
    step(8);
    check_bit("sync_ready_prewrap", fcw_ready, 1'b0);
    step(1);
    check_bit("sync_ready_wrap", fcw_ready, 1'b1);
    sync_update = 1'b0;
    step(3);
    check("sync_i0", carrier_i, L0);
    step(1);
    check("sync_i1", carrier_i, lref(512));
    check("sync_q1", carrier_q, lref(511));
    step(1);
    check("sync_i2", carrier_i, LMAX);

    // Phase offset of half a turn with a frozen accumulator
    fcw_in    = 24'h000000;
    fcw_valid = 1'b1;
    phase_clr = 1'b1;
    step(1);
    fcw_valid = 1'b0;
    phase_clr = 1'b0;
    step(3);
    check("ofs_before", carrier_i, L0);
    phase_ofs = 24'h800000;
    step(2);
    check("ofs_no_early", carrier_i, L0);
    step(1);
    check("ofs_i", carrier_i, neg(L0));
    check("ofs_q", carrier_q, neg(LMAX));
    phase_ofs = 24'h000000;

    // Phase clear while running at 2^20
    fcw_in    = 24'h100000;
    fcw_valid = 1'b1;
    step(1);
    fcw_valid = 1'b0;
    step(5);
    phase_clr = 1'b1;
    step(1);
    phase_clr = 1'b0;
    step(2);
    check("clr_pre", carrier_i, lref(767));
    step(1);
    check("clr_restart", carrier_i, L0);
    step(1);
    check("clr_next", carrier_i, lref(256));

    // Asynchronous reset with a pending word
    fcw_in      = 24'h800000;
    fcw_valid   = 1'b1;
    sync_update = 1'b1;
    step(1);
    fcw_valid   = 1'b0;
    sync_update = 1'b0;
    check_bit("arst_pending", fcw_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_i", carrier_i, 32'd0);
    check("arst_q", carrier_q, 32'd0);
    check_bit("arst_valid", out_valid, 1'b0);
    check_bit("arst_ready", fcw_ready, 1'b1);
    step(1);
    rst = 1'b0;
    step(3);
    check_bit("post_valid", out_valid, 1'b1);
    check_bit("post_ready", fcw_ready, 1'b1);
    check("post_i", carrier_i, L0);
    check("post_q", carrier_q, LMAX);
    step(2);
    check("post_hold_i", carrier_i, L0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
